// File: rtl/fir2d_mac5x5_if.sv
// Bundle of the convolution datapath's coefficient, window and sync signals.
// Tap index is R*5+C (row-major); tap 12 is the window centre.
interface fir2d_mac5x5_if #(
  parameter int DATA_W  = 8,
  parameter int COEFF_W = 16
);
  logic [24:0][COEFF_W-1:0] coeff;
  logic                     coeff_busy;
  logic [24:0][DATA_W-1:0]  pix;
  logic                     dv_i;
  logic                     hs_i;
  logic                     vs_i;
  logic [DATA_W-1:0]        dout;
  logic                     dv_o;
  logic                     hs_o;
  logic                     vs_o;

  modport master (
    output coeff, coeff_busy, pix, dv_i, hs_i, vs_i,
    input  dout, dv_o, hs_o, vs_o
  );

  modport slave (
    input  coeff, coeff_busy, pix, dv_i, hs_i, vs_i,
    output dout, dv_o, hs_o, vs_o
  );
endinterface

// File: rtl/fir2d_mac5x5.sv
// Five-stage pipelined 5x5 convolution with frame-synchronous coefficient shadowing,
// round-half-up and unsigned saturation of the output pixel.
module fir2d_mac5x5 #(
  parameter int DATA_W    = 8,
  parameter int COEFF_W   = 16,
  parameter int FRAC_BITS = 8
) (
  input logic           clk,
  input logic           rst_n,
  fir2d_mac5x5_if.slave bus
);
  localparam int NTAP   = 25;
  localparam int LAT    = 5;
  localparam int PROD_W = DATA_W + 1 + COEFF_W;
  localparam int ROW_W  = PROD_W + 3;
  localparam int SUM_W  = ROW_W + 2;

  localparam logic signed [COEFF_W-1:0] COEFF_ONE = COEFF_W'(1 << FRAC_BITS);
  localparam logic signed [SUM_W:0]     ROUND_ADD = (SUM_W+1)'(1 << (FRAC_BITS-1));
  localparam logic signed [SUM_W:0]     SAT_HI    = (SUM_W+1)'((1 << DATA_W) - 1);

  logic busy_q, busy_d;
  logic vs_prev_q, vs_prev_d;
  logic pending_q, pending_d;
  logic busy_fall, busy_rise, vs_rise, load_en;

  logic signed [COEFF_W-1:0] shadow_q [NTAP];
  logic signed [COEFF_W-1:0] shadow_d [NTAP];

  logic [DATA_W-1:0]         pix_s1_q [NTAP];
  logic [DATA_W-1:0]         pix_s1_d [NTAP];
  logic signed [PROD_W-1:0]  prod_q   [NTAP];
  logic signed [PROD_W-1:0]  prod_d   [NTAP];
  logic signed [ROW_W-1:0]   row_q    [5];
  logic signed [ROW_W-1:0]   row_d    [5];
  logic signed [SUM_W-1:0]   sum_q, sum_d;
  logic signed [SUM_W:0]     rnd_sum, shifted;
  logic [DATA_W-1:0]         dout_q, dout_d;

  // Each entry is {vs, hs, dv}; entry LAT-1 drives the outputs.
  logic [2:0] sync_q [LAT];
  logic [2:0] sync_d [LAT];

  // A load is armed by a finished coefficient write and applied at the next frame start.
  always_comb begin
    busy_d    = bus.coeff_busy;
    vs_prev_d = bus.vs_i;
    busy_fall = busy_q & ~bus.coeff_busy;
    busy_rise = ~busy_q & bus.coeff_busy;
    vs_rise   = ~vs_prev_q & bus.vs_i;
    load_en   = vs_rise & (pending_q | busy_fall);
    pending_d = pending_q;
    if (load_en) begin
      pending_d = 1'b0;
    end else if (busy_fall) begin
      pending_d = 1'b1;
    end else if (busy_rise) begin
      pending_d = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < NTAP; i++) begin
      shadow_d[i] = load_en ? $signed(bus.coeff[i]) : shadow_q[i];
      pix_s1_d[i] = bus.pix[i];
      prod_d[i]   = PROD_W'($signed({1'b0, pix_s1_q[i]})) * PROD_W'(shadow_q[i]);
    end
    for (int r = 0; r < 5; r++) begin
      row_d[r] = '0;
      for (int c = 0; c < 5; c++) begin
        row_d[r] = row_d[r] + ROW_W'(prod_q[r*5+c]);
      end
    end
    sum_d = '0;
    for (int r = 0; r < 5; r++) begin
      sum_d = sum_d + SUM_W'(row_q[r]);
    end
    sync_d[0] = {bus.vs_i, bus.hs_i, bus.dv_i};
    for (int k = 1; k < LAT; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // Output stage: round half up, then clamp to the unsigned pixel range.
  always_comb begin
    rnd_sum = (SUM_W+1)'(sum_q) + ROUND_ADD;
    shifted = rnd_sum >>> FRAC_BITS;
    dout_d  = '0;
    if (sync_q[LAT-2][0]) begin
      if (shifted[SUM_W]) begin
        dout_d = '0;
      end else if (shifted > SAT_HI) begin
        dout_d = '1;
      end else begin
        dout_d = shifted[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= 1'b0;
      vs_prev_q <= 1'b0;
      pending_q <= 1'b0;
      for (int i = 0; i < NTAP; i++) begin
        shadow_q[i] <= (i == 12) ? COEFF_ONE : '0;
        pix_s1_q[i] <= '0;
        prod_q[i]   <= '0;
      end
      for (int r = 0; r < 5; r++) begin
        row_q[r] <= '0;
      end
      sum_q  <= '0;
      dout_q <= '0;
      for (int k = 0; k < LAT; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      busy_q    <= busy_d;
      vs_prev_q <= vs_prev_d;
      pending_q <= pending_d;
      for (int i = 0; i < NTAP; i++) begin
        shadow_q[i] <= shadow_d[i];
        pix_s1_q[i] <= pix_s1_d[i];
        prod_q[i]   <= prod_d[i];
      end
      for (int r = 0; r < 5; r++) begin
        row_q[r] <= row_d[r];
      end
      sum_q  <= sum_d;
      dout_q <= dout_d;
      for (int k = 0; k < LAT; k++) begin
        sync_q[k] <= sync_d[k];
      end
    end
  end

  assign bus.dout = dout_q;
  assign bus.dv_o = sync_q[LAT-1][0];
  assign bus.hs_o = sync_q[LAT-1][1];
  assign bus.vs_o = sync_q[LAT-1][2];
endmodule

// File: tb/tb_fir2d_mac5x5.sv
// Self-checking bench for fir2d_mac5x5: directed table, hand-written shadow/reset
// sequences and a random stream, all compared against a per-cycle reference model.
module tb_fir2d_mac5x5;
  localparam int DATA_W    = 8;
  localparam int COEFF_W   = 16;
  localparam int FRAC_BITS = 8;
  localparam int NTAP      = 25;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fir2d_mac5x5_if #(.DATA_W(DATA_W), .COEFF_W(COEFF_W)) bus ();

  fir2d_mac5x5 #(.DATA_W(DATA_W), .COEFF_W(COEFF_W), .FRAC_BITS(FRAC_BITS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic signed [15:0] c_all;
    logic signed [15:0] c22;
    logic [7:0]         p_all;
    logic [7:0]         p22;
    logic [7:0]         exp;
  } vec_t;

  logic signed [COEFF_W-1:0] cin [NTAP];
  logic [DATA_W-1:0]         px  [NTAP];

  // Reference model state: active coefficients, armed flag, previous busy/vs, output delay line.
  int         m_sh [NTAP];
  bit         m_pend;
  logic       m_bprev, m_vprev;
  logic [10:0] m_q [$];

  int n_vec = 0;
  int n_bad = 0;

  function automatic logic [10:0] outs();
    return {bus.vs_o, bus.hs_o, bus.dv_o, bus.dout};
  endfunction

  function automatic void check(input string name, input logic [10:0] got, input logic [10:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got vs/hs/dv/dout=%b/%b/%b/%0d required %b/%b/%b/%0d",
               name, got[10], got[9], got[8], got[7:0], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endfunction

  function automatic void model_reset();
    m_q.delete();
    repeat (4) m_q.push_back(11'd0);
    for (int i = 0; i < NTAP; i++) m_sh[i] = (i == 12) ? (1 << FRAC_BITS) : 0;
    m_pend  = 1'b0;
    m_bprev = 1'b0;
    m_vprev = 1'b0;
  endfunction

  function automatic logic [7:0] model_pix();
    int acc;
    acc = 0;
    for (int i = 0; i < NTAP; i++) acc += int'(px[i]) * m_sh[i];
    acc = (acc + (1 << (FRAC_BITS - 1))) >>> FRAC_BITS;
    if (acc < 0) return 8'd0;
    if (acc > 255) return 8'd255;
    return 8'(acc);
  endfunction

  task automatic drive(input logic busy, input logic dv, input logic hs, input logic vs);
    for (int i = 0; i < NTAP; i++) begin
      bus.coeff[i] = cin[i];
      bus.pix[i]   = px[i];
    end
    bus.coeff_busy = busy;
    bus.dv_i       = dv;
    bus.hs_i       = hs;
    bus.vs_i       = vs;
  endtask

  // Called at a falling edge; applies one cycle of inputs and checks the outputs after the rising edge.
  task automatic step(input logic busy, input logic dv, input logic hs, input logic vs);
    logic fall, brise, vrise;
    logic [10:0] exp;
    drive(busy, dv, hs, vs);
    @(posedge clk);
    fall  = m_bprev && !busy;
    brise = !m_bprev && busy;
    vrise = !m_vprev && vs;
    if (vrise && (m_pend || fall)) begin
      for (int i = 0; i < NTAP; i++) m_sh[i] = int'(cin[i]);
      m_pend = 1'b0;
    end else if (fall) begin
      m_pend = 1'b1;
    end else if (brise) begin
      m_pend = 1'b0;
    end
    m_bprev = busy;
    m_vprev = vs;
    m_q.push_back({vs, hs, dv, dv ? model_pix() : 8'd0});
    exp = m_q.pop_front();
    #1;
    check("stream", outs(), exp);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic busy);
    for (int i = 0; i < n; i++) step(busy, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_coeffs(input logic signed [15:0] c_all, input logic signed [15:0] c22);
    for (int i = 0; i < NTAP; i++) cin[i] = (i == 12) ? c22 : c_all;
  endtask

  task automatic set_pix(input logic [7:0] p_all, input logic [7:0] p22);
    for (int i = 0; i < NTAP; i++) px[i] = (i == 12) ? p22 : p_all;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    check("reset_async", outs(), 11'd0);
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("reset_hold", outs(), 11'd0);
    rst_n = 1'b1;
  endtask

  vec_t tbl [8];
  logic rb, rv;

  initial begin
    tbl[0] = '{c_all: 16'sd10,  c22: 16'sd10,   p_all: 8'd200, p22: 8'd200, exp: 8'd195};
    tbl[1] = '{c_all: 16'sd0,   c22: 16'sd512,  p_all: 8'd0,   p22: 8'd200, exp: 8'd255};
    tbl[2] = '{c_all: 16'sd0,   c22: -16'sd256, p_all: 8'd0,   p22: 8'd50,  exp: 8'd0};
    tbl[3] = '{c_all: 16'sd0,   c22: 16'sd128,  p_all: 8'd0,   p22: 8'd3,   exp: 8'd2};
    tbl[4] = '{c_all: 16'sd0,   c22: 16'sd128,  p_all: 8'd0,   p22: 8'd1,   exp: 8'd1};
    tbl[5] = '{c_all: 16'sd1,   c22: 16'sd1,    p_all: 8'd255, p22: 8'd255, exp: 8'd25};
    tbl[6] = '{c_all: -16'sd10, c22: -16'sd10,  p_all: 8'd200, p22: 8'd200, exp: 8'd0};
    tbl[7] = '{c_all: -16'sd1,  c22: 16'sd300,  p_all: 8'd100, p22: 8'd100, exp: 8'd108};

    set_coeffs(16'sd0, 16'sd0);
    set_pix(8'd0, 8'd0);
    #1;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #1;
    check("reset_state", outs(), 11'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Identity filter straight out of reset, single valid window.
    set_pix(8'd0, 8'd100);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b0);
    check("ident_out", outs(), {3'b001, 8'd100});
    idle(1, 1'b0);
    check("ident_after", outs(), 11'd0);

    for (int t = 0; t < 8; t++) begin
      set_coeffs(tbl[t].c_all, tbl[t].c22);
      load();
      set_pix(tbl[t].p_all, tbl[t].p22);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      idle(4, 1'b0);
      check($sformatf("table%0d", t), outs(), {3'b001, tbl[t].exp});
    end

    // Mid-frame reload is held back until the next frame start.
    set_coeffs(16'sd0, 16'sd512);
    load();
    set_coeffs(16'sd10, 16'sd10);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    set_pix(8'd100, 8'd100);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b0);
    check("midframe_old", outs(), {3'b001, 8'd200});
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b0);
    check("after_vs", outs(), {3'b001, 8'd98});

    // Busy fall and frame start on the same edge: window in that cycle already uses new taps.
    set_coeffs(16'sd0, 16'sd128);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    set_pix(8'd200, 8'd200);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    set_pix(8'd0, 8'd200);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b0);
    check("coinc_old", outs(), {3'b001, 8'd195});
    idle(1, 1'b0);
    check("coinc_new", outs(), {3'b101, 8'd100});

    // A new busy period cancels an armed load.
    set_coeffs(16'sd1, 16'sd1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    set_pix(8'd0, 8'd200);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(4, 1'b1);
    check("cancel", outs(), {3'b101, 8'd100});

    // Reset while streaming.
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < NTAP; k++) px[k] = 8'($urandom);
      step(1'b1, 1'b1, 1'($urandom), 1'b0);
    end
    reset_pulse();
    set_pix(8'd0, 8'd100);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b0);
    check("post_reset", outs(), {3'b001, 8'd100});

    rb = 1'b0;
    rv = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 19) == 0) rb = ~rb;
      if ($urandom_range(0, 14) == 0) rv = ~rv;
      if (rb) begin
        for (int k = 0; k < NTAP; k++) begin
          if ($urandom_range(0, 1) == 1) cin[k] = 16'($urandom);
          else cin[k] = 16'($urandom_range(0, 600) - 300);
        end
      end
      for (int k = 0; k < NTAP; k++) px[k] = 8'($urandom);
      step(rb, ($urandom_range(0, 3) != 0), 1'($urandom), rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/fir2d_mac5x5.md
Name: fir2d_mac5x5

Overview:
Pipelined 5x5 convolution datapath directly downstream of the coefficient loader. Consumes the 25 signed coefficients and a 5x5 pixel window from the line-buffer stage. Produces one filtered, rounded and saturated pixel per clock, with video syncs delayed to match. Coefficients are shadowed so a reload never takes effect mid-frame.

Parameters:
DATA_W, 8, pixel width (unsigned)
COEFF_W, 16, coefficient width (signed two's complement)
FRAC_BITS, 8, fractional bits of coefficient fixed-point format

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
coeffRC  in  COEFF_W each  25 signed coefficient inputs, R,C in 0..4 (coeff00..coeff44), row-major, from loader
coeff_busy  in  1  loader busy flag (loader's en_d); high while coefficient inputs are changing
pixRC  in  DATA_W each  25 window pixels pix00..pix44, pix22 = centre, same RC indexing as coefficients
dv_i  in  1  window valid
hs_i  in  1  horizontal sync, aligned with window
vs_i  in  1  vertical sync, aligned with window
dout  out  DATA_W  filtered pixel
dv_o  out  1  dv_i delayed by LAT
hs_o  out  1  hs_i delayed by LAT
vs_o  out  1  vs_i delayed by LAT

Behaviour:
- Reset (async, rst_n=0):
  - all pipeline registers, dout, dv_o, hs_o and vs_o = 0
  - pending flag = 0
  - shadow coefficients = identity: shadow22 = 1<<FRAC_BITS, all others 0
- Shadow update:
  - Detect coeff_busy falling edge (registered previous value 1, current 0); set pending.
  - On a vs_i rising edge (registered vs_i 0 -> 1) with pending set, or pending being set in that same cycle: copy all 25 coeffRC inputs into shadow and clear pending.
  - A busy fall with no later vs_i rise never updates the shadow.
  - A busy rise while pending is set clears pending; only a completed load is applied.
  - The datapath uses only shadow values.
- Pipeline, LAT = 5, fully pipelined, one result per clock, no stalls:
  - S1: register pixRC, dv/hs/vs.
  - S2: 25 products. Each pixel is zero-extended to DATA_W+1 signed, multiplied by its shadow coefficient; result width DATA_W+1+COEFF_W (25 b).
  - S3: five row sums, each of 5 products, 28 b signed.
  - S4: total sum of the five row sums, 30 b signed; no overflow is possible at default widths.
  - S5: add 2^(FRAC_BITS-1), arithmetic shift right by FRAC_BITS (round half up). Saturate: result <0 gives 0; result >2^DATA_W-1 gives 2^DATA_W-1.
- Sync handling:
  - dv/hs/vs travel through a 5-stage shift alongside the data; input at edge n appears at the output on edge n+5.
  - dout is forced to 0 whenever dv_o = 0.
  - hs/vs are pure delays, independent of dv.
- A shadow update on edge n affects windows entering S2 on edge n+1 or later. Windows already past S2 keep their old products; the frame boundary is clean because update happens during sync.
- Reset mid-frame clears everything; outputs stay 0 until new valid data has propagated 5 cycles.

Test Plan:
- Reset, no load; all pixels 0 except pix22=100, dv_i=1 one cycle -> dout=100, dv_o=1 exactly 5 clocks later, dout=0 otherwise.
- Load all coeffs=10 (busy pulse, then vs_i rise); all pixels 200 -> sum 50000, +128 >>8 = dout 195.
- coeff22=512 (2.0), others 0, pix22=200 -> 400 saturates, dout 255; coeff22=-256, pix22=50 -> dout 0.
- Rounding: coeff22=128 (0.5): pix22=3 -> (384+128)>>8 = dout 2; pix22=1 -> (128+128)>>8 = dout 1.
- Shadow timing:
  - Change coeffs and pulse busy mid-frame (vs_i low) -> outputs keep old filter.
  - After vs_i rise, new filter applies.
  - Busy fall coincident with vs_i rise -> update applied that cycle.
- Assert rst_n low while dv_i streaming -> dv_o/hs_o/vs_o/dout 0 immediately; shadow back to identity; first output 5 clocks after the next dv_i.
